iic_txn_ctrl: RTL
=================

Name: iic_txn_ctrl

Overview:
- Transaction sequencer in front of iic_core (byte-level I2C engine: start / write / read / stop, busy handshake).
- Accepts one register-oriented command from a host: device address, register address, direction, byte count.
- Issues the byte operations to iic_core in order, streams write data in, and pulses read data out.
- Reports completion and timeout errors. Register reads use stop + new start (iic_core has no repeated start).

Parameters:
- LEN_W, 4, width of cmd_len; max burst is 2^LEN_W-1 bytes.
- OP_TO, 64, cycles allowed per byte operation (issue to busy-fall) before timeout.
- STOP_CYC, 3, cycles waited after core_stop before the bus counts as idle.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  1 = read
- cmd_dev  in  7  7-bit device address
- cmd_reg  in  8  register address
- cmd_len  in  LEN_W  data byte count
- wr_valid  in  1  write byte available
- wr_data  in  8  write byte
- wr_ready  out  1  one-cycle pulse, wr_data consumed
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  read byte
- done  out  1  one-cycle pulse, transaction finished
- err  out  1  valid with done; 1 = timeout or illegal command
- core_start  out  1  to iic_core start
- core_stop  out  1  to iic_core stop
- core_rw  out  1  to iic_core rw
- core_din  out  8  to iic_core din
- core_busy  in  1  from iic_core busy
- core_dout  in  8  from iic_core dout

Behaviour:
- Reset (async assert, sync release): state IDLE, cmd_ready=1, all other outputs 0, counters 0. Reset mid-transaction abandons it; no done is issued. iic_core shares reset_n.
- Accept: cmd_valid & cmd_ready latches rw/dev/reg/len; cmd_ready drops the next cycle.
- Byte op (op issuer):
  - core_start high exactly one cycle with core_rw/core_din stable.
  - Then wait for core_busy=1, then for core_busy=0. The rise arrives 1–2 cycles after issue.
  - The op completes on the first cycle busy is seen 0 after the rise.
  - The timeout counter starts at issue. Reaching OP_TO goes to STOP with err_flag set.
- States:
  - IDLE
  - W_DEV: din={dev,0}
  - W_REG: din=reg
  - W_DATA
  - STOP: core_stop pulse one cycle
  - STOP_WAIT: STOP_CYC cycles
  - R_DEV: din={dev,1}, rw=0
  - R_DATA: rw=1
  - FIN
- Write path: IDLE→W_DEV→W_REG→(len>0: W_DATA × len)→STOP→STOP_WAIT→FIN.
- Read path: IDLE→W_DEV→W_REG→STOP→STOP_WAIT→R_DEV→R_DATA × len→STOP→STOP_WAIT→FIN.
- W_DATA: op is not issued until wr_valid=1. wr_ready pulses in the same cycle as core_start; core_din=wr_data. Stalling is legal indefinitely, since the core holds in its wait state.
- R_DATA: on op completion, rd_data<=core_dout and rd_valid pulses one cycle. No backpressure.
- Byte counter decrements per completed data op; the last byte goes to STOP.
- FIN: done=1, err=err_flag for one cycle, then IDLE.
- Write with len=0 is legal (pointer set only).
- Read with len=0: done+err the cycle after accept, no bus activity.
- Timeout in any op: core_stop is still issued, STOP_WAIT runs, then done+err.
- Core ACK is not checked (not available from iic_core).
- cmd_* and wr_* changes outside handshakes are ignored.

Decomposition:
- Shared package iic_pkg: state encodings; the R/W bit constants (READ=1, WRITE=0); the address-byte builder {dev,rw}.
- Sub-module iic_op_issuer: start pulse, busy rise/fall tracking, OP_TO counter. Ports are go/rw/din in, ack/timeout out.
- Top module holds the transaction FSM and byte counter.

Test Plan:
- Write dev=0x50, reg=0x10, len=2, data 0xA5, 0x3C, core model present → core_din sequence 0xA0, 0x10, 0xA5, 0x3C; two wr_ready pulses; one core_stop; done=1, err=0.
- Read dev=0x50, reg=0x02, len=3, model returns 0x11, 0x22, 0x33 → core_din 0xA0, 0x02, stop, 0xA1, three rw=1 ops; rd_valid ×3 with 0x11, 0x22, 0x33; done, err=0.
- Write len=2 with wr_valid withheld 20 cycles before the second byte → no core_start during the stall; completes normally; no timeout.
- core_busy tied 0 → after OP_TO=64 cycles core_stop pulses, then done=1, err=1; back in IDLE with cmd_ready=1.
- Read len=0 → done+err one cycle after accept; core_start never asserted.
- reset_n low mid-W_REG → all outputs 0 and cmd_ready=1 immediately after release; a new write then completes correctly.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared state encodings, R/W bit constants and address-byte builder for the I2C transaction sequencer
package iic_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_DEV,
      S_W_REG,
      S_W_DATA,
      S_STOP,
      S_STOP_WAIT,
      S_R_DEV,
      S_R_DATA,
      S_FIN
   } txn_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_RISE,
      P_FALL
   } op_phase_t;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
      return {dev, rw};
   endfunction

endpackage

// File: rtl/iic_op_issuer.sv
// iic_op_issuer: launches one iic_core byte op and reports completion (busy rise then fall) or timeout
module iic_op_issuer
   import iic_pkg::*;
#(
   parameter int OP_TO = 64
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       go,
   input  logic       rw,
   input  logic [7:0] din,
   input  logic       core_busy,
   output logic       core_start,
   output logic       core_rw,
   output logic [7:0] core_din,
   output logic       ack,
   output logic       timeout
);

   localparam int CW = $clog2(OP_TO + 1);

   op_phase_t     phase;
   logic [CW-1:0] cnt;

   // completion is the first cycle busy reads low after its rise; timeout loses to a same-cycle completion
   assign ack     = (phase == P_FALL) && !core_busy;
   assign timeout = (phase != P_IDLE) && !ack && (cnt == CW'(OP_TO));

   // one-cycle start pulse with rw/din held, then track busy rise/fall while counting toward timeout
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase      <= P_IDLE;
         cnt        <= '0;
         core_start <= 1'b0;
         core_rw    <= 1'b0;
         core_din   <= '0;
      end else begin
         core_start <= 1'b0;
         if (phase == P_IDLE) begin
            if (go) begin
               phase      <= P_RISE;
               cnt        <= '0;
               core_start <= 1'b1;
               core_rw    <= rw;
               core_din   <= din;
            end
         end else if (ack || timeout) begin
            phase <= P_IDLE;
         end else begin
            cnt <= cnt + CW'(1);
            if (phase == P_RISE && core_busy)
               phase <= P_FALL;
         end
      end
   end

endmodule

// File: rtl/iic_txn_ctrl.sv
// iic_txn_ctrl: sequences a register-oriented read/write command into iic_core byte ops
module iic_txn_ctrl
   import iic_pkg::*;
#(
   parameter int LEN_W    = 4,
   parameter int OP_TO    = 64,
   parameter int STOP_CYC = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rw,
   input  logic [6:0]       cmd_dev,
   input  logic [7:0]       cmd_reg,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wr_valid,
   input  logic [7:0]       wr_data,
   output logic             wr_ready,
   output logic             rd_valid,
   output logic [7:0]       rd_data,
   output logic             done,
   output logic             err,
   output logic             core_start,
   output logic             core_stop,
   output logic             core_rw,
   output logic [7:0]       core_din,
   input  logic             core_busy,
   input  logic [7:0]       core_dout
);

   localparam int SW = $clog2(STOP_CYC + 1);

   txn_state_t       state, next_op;
   logic             rw_q, err_flag, issued, second;
   logic [6:0]       dev_q;
   logic [7:0]       reg_q, op_din;
   logic [LEN_W-1:0] cnt;
   logic [SW-1:0]    scnt;
   logic             is_op, go, op_rw, ack, timeout;

   // op request, operand mux and the state that follows a completed op
   always_comb begin
      is_op   = state inside {S_W_DEV, S_W_REG, S_W_DATA, S_R_DEV, S_R_DATA};
      go      = is_op && !issued && (state != S_W_DATA || wr_valid);
      op_rw   = state == S_R_DATA;
      op_din  = state == S_W_DEV  ? addr_byte(dev_q, WRITE) :
                state == S_W_REG  ? reg_q :
                state == S_W_DATA ? wr_data :
                state == S_R_DEV  ? addr_byte(dev_q, READ) : 8'h00;
      next_op = state == S_W_DEV ? S_W_REG :
                state == S_W_REG ? ((rw_q || cnt == '0) ? S_STOP : S_W_DATA) :
                state == S_R_DEV ? S_R_DATA :
                cnt == LEN_W'(1) ? S_STOP : state;
   end

   iic_op_issuer #(.OP_TO(OP_TO)) u_issuer (
      .clock      (clock),
      .reset_n    (reset_n),
      .go         (go),
      .rw         (op_rw),
      .din        (op_din),
      .core_busy  (core_busy),
      .core_start (core_start),
      .core_rw    (core_rw),
      .core_din   (core_din),
      .ack        (ack),
      .timeout    (timeout)
   );

   // transaction FSM: accept, walk the op sequence, stop/settle, then report
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         rw_q      <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         cnt       <= '0;
         scnt      <= '0;
         err_flag  <= 1'b0;
         issued    <= 1'b0;
         second    <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         core_stop <= 1'b0;
      end else begin
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         core_stop <= 1'b0;
         if (go) begin
            issued   <= 1'b1;
            wr_ready <= state == S_W_DATA;
         end
         case (state)
            S_IDLE: if (cmd_valid && cmd_ready) begin
               cmd_ready <= 1'b0;
               rw_q      <= cmd_rw;
               dev_q     <= cmd_dev;
               reg_q     <= cmd_reg;
               cnt       <= cmd_len;
               second    <= 1'b0;
               err_flag  <= cmd_rw && cmd_len == '0;
               done      <= cmd_rw && cmd_len == '0;
               err       <= cmd_rw && cmd_len == '0;
               state     <= (cmd_rw && cmd_len == '0) ? S_FIN : S_W_DEV;
            end
            S_STOP: begin
               core_stop <= 1'b1;
               scnt      <= '0;
               state     <= S_STOP_WAIT;
            end
            S_STOP_WAIT: if (scnt == SW'(STOP_CYC - 1)) begin
               if (rw_q && !second && !err_flag) begin
                  second <= 1'b1;
                  state  <= S_R_DEV;
               end else begin
                  done  <= 1'b1;
                  err   <= err_flag;
                  state <= S_FIN;
               end
            end else begin
               scnt <= scnt + SW'(1);
            end
            S_FIN: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: if (timeout) begin
               issued   <= 1'b0;
               err_flag <= 1'b1;
               state    <= S_STOP;
            end else if (ack) begin
               issued <= 1'b0;
               if (state == S_R_DATA) begin
                  rd_valid <= 1'b1;
                  rd_data  <= core_dout;
               end
               if (state inside {S_W_DATA, S_R_DATA})
                  cnt <= cnt - LEN_W'(1);
               state <= next_op;
            end
         endcase
      end
   end

endmodule
